// File: rtl/ps2_pkg.sv
// ============================================================================
// Module : ps2_pkg
// Brief  : Scan-code set 2 constants and the scan-code to ASCII lookup.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

    localparam int          FRAME_LEN   = 11;
    localparam int          ASCII_WIDTH = 7;

    localparam logic [7:0]  SC_E0     = 8'hE0;
    localparam logic [7:0]  SC_F0     = 8'hF0;
    localparam logic [7:0]  SC_LSHIFT = 8'h12;
    localparam logic [7:0]  SC_RSHIFT = 8'h59;
    localparam logic [7:0]  SC_BKSP   = 8'h66;
    localparam logic [7:0]  SC_LEFT   = 8'h6B;
    localparam logic [7:0]  SC_RIGHT  = 8'h74;
    localparam logic [7:0]  SC_SLASH  = 8'h4A;

    // Returns 0 for codes with no printable mapping.
    function automatic logic [ASCII_WIDTH-1:0] scancode_to_ascii(
        input logic [7:0] code,
        input logic       shift
    );
        logic [ASCII_WIDTH-1:0] a;
        a = '0;
        case (code)
            8'h1C: a = 7'h61;
            8'h32: a = 7'h62;
            8'h21: a = 7'h63;
            8'h23: a = 7'h64;
            8'h24: a = 7'h65;
            8'h2B: a = 7'h66;
            8'h34: a = 7'h67;
            8'h33: a = 7'h68;
            8'h43: a = 7'h69;
            8'h3B: a = 7'h6A;
            8'h42: a = 7'h6B;
            8'h4B: a = 7'h6C;
            8'h3A: a = 7'h6D;
            8'h31: a = 7'h6E;
            8'h44: a = 7'h6F;
            8'h4D: a = 7'h70;
            8'h15: a = 7'h71;
            8'h2D: a = 7'h72;
            8'h1B: a = 7'h73;
            8'h2C: a = 7'h74;
            8'h3C: a = 7'h75;
            8'h2A: a = 7'h76;
            8'h1D: a = 7'h77;
            8'h22: a = 7'h78;
            8'h35: a = 7'h79;
            8'h1A: a = 7'h7A;
            8'h45: a = shift ? 7'h29 : 7'h30;
            8'h16: a = 7'h31;
            8'h1E: a = 7'h32;
            8'h26: a = 7'h33;
            8'h25: a = 7'h34;
            8'h2E: a = 7'h35;
            8'h36: a = 7'h36;
            8'h3D: a = 7'h37;
            8'h3E: a = shift ? 7'h2A : 7'h38;
            8'h46: a = shift ? 7'h28 : 7'h39;
            8'h55: a = shift ? 7'h2B : 7'h3D;
            8'h4E: a = 7'h2D;
            8'h49: a = 7'h2E;
            8'h4A: a = 7'h2F;
            8'h79: a = 7'h2B;
            8'h7C: a = 7'h2A;
            8'h7B: a = 7'h2D;
            default: a = '0;
        endcase
        return a;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_rx.sv
// ============================================================================
// Module : ps2_rx
// Brief  : PS/2 line synchronizer and 11-bit frame deserializer with timeout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2560
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_error
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    logic              clk_s1_q, clk_s2_q, clk_prev_q;
    logic              dat_s1_q, dat_s2_q;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [10:0]       shift_q, shift_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [7:0]        byte_q, byte_d;
    logic              byte_valid_q, byte_valid_d;
    logic              frame_error_q, frame_error_d;
    logic              fall;

    assign fall = clk_prev_q & ~clk_s2_q;

    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        tmo_d         = tmo_q;
        byte_d        = byte_q;
        byte_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        if (fall) begin
            tmo_d   = '0;
            // Bits arrive LSB first, so shift in from the top.
            shift_d = {dat_s2_q, shift_q[10:1]};
            if (bit_cnt_q == 4'(FRAME_LEN - 1)) begin
                bit_cnt_d = '0;
                if (!shift_d[0] && shift_d[10] && (^shift_d[9:1])) begin
                    byte_d       = shift_d[8:1];
                    byte_valid_d = 1'b1;
                end else begin
                    frame_error_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != '0) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt_d = '0;
                tmo_d     = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q      <= 1'b1;
            clk_s2_q      <= 1'b1;
            clk_prev_q    <= 1'b1;
            dat_s1_q      <= 1'b1;
            dat_s2_q      <= 1'b1;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            tmo_q         <= '0;
            byte_q        <= '0;
            byte_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            clk_s1_q      <= ps2_clk;
            clk_s2_q      <= clk_s1_q;
            clk_prev_q    <= clk_s2_q;
            dat_s1_q      <= ps2_data;
            dat_s2_q      <= dat_s1_q;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            tmo_q         <= tmo_d;
            byte_q        <= byte_d;
            byte_valid_q  <= byte_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign rx_byte     = byte_q;
    assign byte_valid  = byte_valid_q;
    assign frame_error = frame_error_q;

endmodule

`default_nettype wire

// File: rtl/ps2_keyboard.sv
// ============================================================================
// Module : ps2_keyboard
// Brief  : PS/2 keyboard front end producing one-cycle edit/symbol strobes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int SYMBOL_WIDTH   = 7,
    parameter int TIMEOUT_CYCLES = 2560
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ps2_clk,
    input  logic                    ps2_data,
    output logic                    left,
    output logic                    right,
    output logic                    backspace,
    output logic [SYMBOL_WIDTH-1:0] symbol
);

    logic [7:0]              rx_byte;
    logic                    byte_valid;
    logic                    frame_error;
    logic [ASCII_WIDTH-1:0]  ascii;

    logic ext_q, ext_d, brk_q, brk_d;
    logic shl_q, shl_d, shr_q, shr_d;
    logic left_q, left_d, right_q, right_d, bksp_q, bksp_d;
    logic [SYMBOL_WIDTH-1:0] symbol_q, symbol_d;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rx_byte     (rx_byte),
        .byte_valid  (byte_valid),
        .frame_error (frame_error)
    );

    assign ascii = scancode_to_ascii(rx_byte, shl_q | shr_q);

    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        shl_d    = shl_q;
        shr_d    = shr_q;
        left_d   = 1'b0;
        right_d  = 1'b0;
        bksp_d   = 1'b0;
        symbol_d = '0;
        if (frame_error) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_valid) begin
            if (rx_byte == SC_E0) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_F0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                // Break codes only matter for releasing shift.
                if (brk_q) begin
                    if (rx_byte == SC_LSHIFT) shl_d = 1'b0;
                    if (rx_byte == SC_RSHIFT) shr_d = 1'b0;
                end else if (ext_q) begin
                    if (rx_byte == SC_LEFT)  left_d   = 1'b1;
                    if (rx_byte == SC_RIGHT) right_d  = 1'b1;
                    if (rx_byte == SC_SLASH) symbol_d = SYMBOL_WIDTH'(ascii);
                end else if (rx_byte == SC_LSHIFT) begin
                    shl_d = 1'b1;
                end else if (rx_byte == SC_RSHIFT) begin
                    shr_d = 1'b1;
                end else if (rx_byte == SC_BKSP) begin
                    bksp_d = 1'b1;
                end else begin
                    symbol_d = SYMBOL_WIDTH'(ascii);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            shl_q    <= 1'b0;
            shr_q    <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            bksp_q   <= 1'b0;
            symbol_q <= '0;
        end else begin
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            shl_q    <= shl_d;
            shr_q    <= shr_d;
            left_q   <= left_d;
            right_q  <= right_d;
            bksp_q   <= bksp_d;
            symbol_q <= symbol_d;
        end
    end

    assign left      = left_q;
    assign right     = right_q;
    assign backspace = bksp_q;
    assign symbol    = symbol_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
// ============================================================================
// Module : tb_ps2_keyboard
// Brief  : Scoreboard bench for ps2_keyboard driven by PS/2 frames.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_keyboard;

    localparam int HALF = 10;
    localparam int TMO  = 200;
    localparam int LAT  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       left, right, backspace;
    logic [6:0] symbol;

    ps2_keyboard #(
        .SYMBOL_WIDTH   (7),
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .left      (left),
        .right     (right),
        .backspace (backspace),
        .symbol    (symbol)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   stop_cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   fe_seen = 0;
    int   fe_exp = 0;
    int   plain_tab[256];
    int   shift_tab[256];
    bit   m_ext, m_brk, m_shl, m_shr;

    always @(posedge clk) cyc <= cyc + 1;

    // Kinds: 0 left, 1 right, 2 backspace, 3 symbol.
    task automatic push(input int kind, input int val);
        q.push_back('{kind, val});
    endtask

    task automatic model_byte(input int b);
        int a;
        if (b == 'hE0) m_ext = 1;
        else if (b == 'hF0) m_brk = 1;
        else begin
            if (m_brk) begin
                if (b == 'h12) m_shl = 0;
                if (b == 'h59) m_shr = 0;
            end else if (m_ext) begin
                if (b == 'h6B) push(0, 0);
                else if (b == 'h74) push(1, 0);
                else if (b == 'h4A) push(3, 'h2F);
            end else if (b == 'h12) m_shl = 1;
            else if (b == 'h59) m_shr = 1;
            else if (b == 'h66) push(2, 0);
            else begin
                a = (m_shl || m_shr) ? shift_tab[b] : plain_tab[b];
                if (a != 0) push(3, a);
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic send_bits(input int b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        logic [7:0]  d;
        d     = b[7:0];
        f[0]  = 1'b0;
        f[8:1] = d;
        f[9]  = (~^d) ^ bad_par;
        f[10] = ~bad_stop;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_frame(input int b);
        model_byte(b);
        send_bits(b, 0, 0, 11);
    endtask

    task automatic send_bad(input int b, input bit bad_par, input bit bad_stop);
        fe_exp++;
        m_ext = 0;
        m_brk = 0;
        send_bits(b, bad_par, bad_stop, 11);
    endtask

    task automatic send_partial(input int b, input int nbits);
        send_bits(b, 0, 0, nbits);
        repeat (TMO + 10) @(negedge clk);
    endtask

    // Monitor: any strobe must match the head of the expected queue.
    always @(negedge clk) begin
        int na, k, v;
        exp_t e;
        if (rst_n) begin
            if (u_dut.frame_error) fe_seen++;
            na = int'(left) + int'(right) + int'(backspace) + int'(symbol != 0);
            if (na != 0) begin
                k = left ? 0 : right ? 1 : backspace ? 2 : 3;
                v = (k == 3) ? int'(symbol) : 0;
                n_cmp++;
                if (na > 1) begin
                    n_err++;
                    $display("FAIL onehot: %0d strobes active, required 1", na);
                end
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected: kind %0d val 0x%0h, required none", k, v);
                end else begin
                    e = q.pop_front();
                    if (e.kind != k || e.val != v) begin
                        n_err++;
                        $display("FAIL strobe: kind %0d val 0x%0h, required kind %0d val 0x%0h",
                                 k, v, e.kind, e.val);
                    end
                    n_cmp++;
                    if (cyc - stop_cyc != LAT) begin
                        n_err++;
                        $display("FAIL latency: %0d cycles, required %0d", cyc - stop_cyc, LAT);
                    end
                end
            end
        end
    end

    task automatic check_idle(input string name);
        n_cmp++;
        if (left || right || backspace || symbol != 0) begin
            n_err++;
            $display("FAIL %s: l%0b r%0b b%0b s0x%0h, required all 0",
                     name, left, right, backspace, symbol);
        end
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d expected strobes missing, required 0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        int lc[26] = '{'h1C, 'h32, 'h21, 'h23, 'h24, 'h2B, 'h34, 'h33, 'h43, 'h3B,
                       'h42, 'h4B, 'h3A, 'h31, 'h44, 'h4D, 'h15, 'h2D, 'h1B, 'h2C,
                       'h3C, 'h2A, 'h1D, 'h22, 'h35, 'h1A};
        int dc[10] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};
        int pool[24] = '{'hE0, 'hF0, 'h12, 'h59, 'h66, 'h6B, 'h74, 'h4A, 'h45, 'h46,
                         'h3E, 'h55, 'h4E, 'h49, 'h79, 'h7C, 'h7B, 'h16, 'h1C, 'h22,
                         'h1A, 'h36, 'hF0, 'hE0};
        int r, b;

        for (int i = 0; i < 256; i++) plain_tab[i] = 0;
        for (int i = 0; i < 26; i++) plain_tab[lc[i]] = 'h61 + i;
        for (int i = 0; i < 10; i++) plain_tab[dc[i]] = 'h30 + i;
        plain_tab['h55] = "=";
        plain_tab['h4E] = "-";
        plain_tab['h49] = ".";
        plain_tab['h4A] = "/";
        plain_tab['h79] = "+";
        plain_tab['h7C] = "*";
        plain_tab['h7B] = "-";
        for (int i = 0; i < 256; i++) shift_tab[i] = plain_tab[i];
        shift_tab['h46] = "(";
        shift_tab['h45] = ")";
        shift_tab['h3E] = "*";
        shift_tab['h55] = "+";

        m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Directed sequences
        send_frame('h16);
        send_frame('hE0); send_frame('h6B);
        send_frame('hE0); send_frame('hF0); send_frame('h6B);
        send_frame('hE0); send_frame('h74);
        send_frame('h66);
        send_frame('hF0); send_frame('h66);
        send_frame('h12); send_frame('h46); send_frame('hF0); send_frame('h46);
        send_frame('hF0); send_frame('h12); send_frame('h46);
        send_frame('h59); send_frame('h45); send_frame('hF0); send_frame('h59);
        send_frame('hE0); send_frame('h4A);
        send_bad('h1C, 1, 0);
        send_bad('hE0, 0, 1);
        send_frame('h6B);
        send_frame('h1C);
        send_partial('h1C, 5);
        send_frame('h22);
        check_drained("directed");

        // Reset in the middle of a frame
        send_bits('h1C, 0, 0, 7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle("reset_midframe");
        @(negedge clk);
        rst_n = 1'b1;
        m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0;
        repeat (5) @(negedge clk);
        send_frame('h45);
        check_drained("after_reset");

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            b = (r < 70) ? pool[$urandom_range(0, 23)] : $urandom_range(0, 255);
            r = $urandom_range(0, 99);
            if (r < 8) send_bad(b, 1, 0);
            else if (r < 12) send_bad(b, 0, 1);
            else if (r < 16) send_partial(b, $urandom_range(1, 10));
            else send_frame(b);
        end

        repeat (20) @(negedge clk);
        check_drained("final_queue");
        n_cmp++;
        if (fe_seen != fe_exp) begin
            n_err++;
            $display("FAIL frame_error_count: %0d, required %0d", fe_seen, fe_exp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- Upstream stage of input_buffer: turns raw PS/2 keyboard line activity into one-cycle left/right/backspace/symbol strobes.
- Contains a frame deserializer (ps2_rx) and a scan-code set 2 decoder that handles the E0 (extended) prefix, the F0 (break) prefix and shift state.
- Outputs drive input_buffer left_in/right_in/backspace_in/symbol_in directly.

Parameters:
- SYMBOL_WIDTH, 7: width of the ASCII symbol output.
- TIMEOUT_CYCLES, 2560: clk cycles without a PS/2 falling edge before a partial frame is discarded (about 100 us at 25.175 MHz).

Ports:
- clk  in  1  system clock, 25.175 MHz.
- rst_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous.
- ps2_data  in  1  raw PS/2 data line, asynchronous.
- left  out  1  one-cycle pulse: cursor-left key pressed.
- right  out  1  one-cycle pulse: cursor-right key pressed.
- backspace  out  1  one-cycle pulse: backspace pressed.
- symbol  out  SYMBOL_WIDTH  ASCII code, valid for one cycle. 0 means no symbol.

Behaviour:
- Reset (async, rst_n=0):
  - left, right, backspace = 0; symbol = 0.
  - Synchronizers preset to 1. Bit counter 0. Prefix flags and shift cleared. Timeout counter 0.
- Input sync: ps2_clk and ps2_data each pass through a 2-FF synchronizer. A falling edge is sync_clk 1→0, seen one cycle after the second FF.
- ps2_rx sampling: on each falling edge, sample sync_data into an 11-bit shift register (LSB-first framing): start, d0..d7, odd parity, stop.
- ps2_rx frame check, after the 11th bit:
  - Valid only if start=0, stop=1, and XOR(d0..d7, parity)=1.
  - Valid frame: pulse byte_valid with byte for 1 cycle, in the cycle after the stop-bit falling edge.
  - Invalid frame: no byte_valid, and pulse frame_error for 1 cycle.
  - Bit counter returns to 0 either way.
- Timeout: the counter increments while bit counter ≠ 0 and clears on each falling edge. On reaching TIMEOUT_CYCLES-1, the bit counter is reset to 0 and the partial frame is dropped (no frame_error).
- Decoder flags: ext and brk, updated on byte_valid:
  - E0: set ext.
  - F0: set brk.
  - Any other byte: decode with the current ext/brk, then clear both.
  - frame_error clears ext and brk.
- Decode, make (brk=0):
  - ext=1: 6B→left, 74→right, 4A→symbol "/". Other extended codes are ignored.
  - ext=0:
    - 66→backspace.
    - 12 or 59: set shift_l or shift_r respectively, no output.
    - Digits 45,16,1E,26,25,2E,36,3D,3E,46 → "0".."9". With shift: 46→"(", 45→")", 3E→"*", 55→"+".
    - 55 (unshifted)→"=". 4E→"-". 49→".". 4A→"/". 79→"+". 7C→"*". 7B→"-".
    - Letters a..z → lowercase ASCII regardless of shift.
    - Unlisted codes: no output.
- Decode, break (brk=1): 12 clears shift_l, 59 clears shift_r. All other break codes produce no output.
- Typematic repeats of make codes produce repeated strobes.
- Latency: output strobe is registered, asserted 1 cycle after byte_valid, i.e. 2 cycles after the synchronized stop-bit falling edge. At most one of left/right/backspace/symbol≠0 is active per cycle.
- Output is not back-pressured: input_buffer latches it. Bytes arrive at ≥ 1 per ~1 ms, so no internal queue is needed.
- Reset mid-frame: all state returns to reset values immediately. The next start bit begins a fresh frame.

Decomposition:
- Package ps2_pkg:
  - Scan-code localparams: SC_E0, SC_F0, SC_LSHIFT, SC_RSHIFT, SC_BKSP, SC_LEFT, SC_RIGHT.
  - Frame length 11.
  - Function scancode_to_ascii(code, shift) returning SYMBOL_WIDTH bits, 0 if unmapped.
- Sub-module ps2_rx: synchronizers, edge detect, shift register, parity/framing check, timeout. Outputs byte, byte_valid, frame_error.
- ps2_keyboard top: prefix/shift FSM and output registers.

Test Plan:
- Frame 0x16 (parity 0, stop 1) → symbol=0x31 for exactly 1 cycle, 2 cycles after the stop edge; all other outputs 0.
- E0,6B then E0,F0,6B → single left pulse; E0,74 → single right pulse; 66 → single backspace pulse; break sequences produce nothing.
- 12, 46, F0 46, F0 12, 46 → "(" then "9"; with 59 used as shift, 45 → ")".
- 0x1C with wrong parity → no output, frame_error pulse. Then E0 with bad stop bit, then 6B → 6B decoded non-extended (unmapped, no output); then 1C → "a".
- 5 bits of a frame, idle for TIMEOUT_CYCLES, then full 0x22 frame → symbol "x", no spurious output.
- rst_n low for 1 cycle mid-frame (bit 6) → outputs 0 immediately; next full 0x45 frame → symbol "0".
